// File: rtl/march_pkg.sv
// Shared definitions for the March C- BIST controller.
//   - element count and per-element sweep direction
//   - memory op encoding (R0, R1, W0, W1) and the element op-list table
//   - controller FSM state type
package march_pkg;

  localparam int NUM_ELEM = 6;
  localparam int MAX_OPS  = 2;

  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    OP_R0 = 2'd0,
    OP_R1 = 2'd1,
    OP_W0 = 2'd2,
    OP_W1 = 2'd3
  } march_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_OP    = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } march_state_e;

  // 1 = ascending sweep; only E3 and E4 sweep downwards.
  function automatic logic elem_up(input logic [2:0] elem);
    return (elem != 3'd3) && (elem != 3'd4);
  endfunction

  // Index of the last op in an element's list: E0 and E5 have one op,
  // the middle elements have a read followed by a write.
  function automatic logic elem_last_idx(input logic [2:0] elem);
    return (elem != 3'd0) && (elem != 3'd5);
  endfunction

  // Element op-list table:
  //   E0 (w0); E1 (r0,w1); E2 (r1,w0); E3 (r0,w1); E4 (r1,w0); E5 (r0)
  function automatic march_op_e elem_op(input logic [2:0] elem, input logic idx);
    march_op_e op;
    op = OP_R0;
    case (elem)
      3'd0:    op = OP_W0;
      3'd1:    op = idx ? OP_W1 : OP_R0;
      3'd2:    op = idx ? OP_W0 : OP_R1;
      3'd3:    op = idx ? OP_W1 : OP_R0;
      3'd4:    op = idx ? OP_W0 : OP_R1;
      default: op = OP_R0;
    endcase
    return op;
  endfunction

  function automatic logic op_is_read(input march_op_e op);
    return (op == OP_R0) || (op == OP_R1);
  endfunction

endpackage

// File: rtl/march_comparator.sv
// Read-data checker for the March BIST.
//   - On i_rd_en, registers the expected pattern, address and element of the
//     read being issued; the following cycle compares it to i_rdata.
//   - o_fail is sticky; the first miscompare's address/element are captured
//     and held until i_clear (an accepted start).
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   i_clear             clears fail and the capture
//   i_rd_en             read strobe issued this cycle
//   i_exp/i_addr/i_elem expected data, address and element of that read
//   i_rdata             memory read data (valid one cycle after i_rd_en)
//   o_fail, o_fail_addr, o_fail_elem   sticky fail and first-fail capture
module march_comparator #(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clear,
  input  logic               i_rd_en,
  input  logic [D_WIDTH-1:0] i_exp,
  input  logic [A_WIDTH-1:0] i_addr,
  input  logic [2:0]         i_elem,
  input  logic [D_WIDTH-1:0] i_rdata,
  output logic               o_fail,
  output logic [A_WIDTH-1:0] o_fail_addr,
  output logic [2:0]         o_fail_elem
);

  logic [D_WIDTH-1:0] r_exp_p0;
  logic [A_WIDTH-1:0] r_addr_p0;
  logic [2:0]         r_elem_p0;
  logic               vld_p0;
  logic               w_miscmp;

  // Stage p0: remember what the outstanding read should return.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_exp_p0  <= i_exp;
      r_addr_p0 <= i_addr;
      r_elem_p0 <= i_elem;
    end
  end

  assign w_miscmp = vld_p0 && (i_rdata != r_exp_p0);

  // Stage p1: compare against returned data; only the first miscompare is kept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p0      <= 1'b0;
      o_fail      <= 1'b0;
      o_fail_addr <= '0;
      o_fail_elem <= '0;
    end else begin
      vld_p0 <= i_rd_en;
      if (i_clear) begin
        o_fail      <= 1'b0;
        o_fail_addr <= '0;
        o_fail_elem <= '0;
      end else if (w_miscmp && !o_fail) begin
        o_fail      <= 1'b1;
        o_fail_addr <= r_addr_p0;
        o_fail_elem <= r_elem_p0;
      end
    end
  end

endmodule

// File: rtl/march_bist_controller.sv
// March C- BIST sequencer.
//   Walks the six March C- elements over an N = 2**A_WIDTH word memory,
//   steering an external address generator and issuing one read or write
//   per cycle; read data is checked by march_comparator.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start                   begin a test (accepted only when idle)
//   busy, done              test in progress / one-cycle completion pulse
//   fail, fail_addr/elem    sticky result and first-miscompare capture
//   ag_clear/preset/en/up_down   address generator control
//   ag_address, ag_carry    generator address and end-of-sweep pulse
//   mem_addr/we/re/wdata    memory port (mem_addr follows ag_address)
//   mem_rdata               memory read data, one cycle after mem_re
module march_bist_controller
  import march_pkg::*;
#(
  parameter int A_WIDTH = 4,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [A_WIDTH-1:0] fail_addr,
  output logic [2:0]         fail_elem,
  output logic               ag_clear,
  output logic               ag_preset,
  output logic               ag_en,
  output logic               ag_up_down,
  input  logic [A_WIDTH-1:0] ag_address,
  input  logic               ag_carry,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic               mem_we,
  output logic               mem_re,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata
);

  march_state_e r_state, w_state_nxt;
  logic [2:0]   r_elem, w_elem_nxt;
  logic         r_op_idx, w_op_idx_nxt;
  march_op_e    w_op;
  logic         w_last_op;
  logic         w_start_acc;
  logic         w_dir_up;

  assign w_op      = elem_op(r_elem, r_op_idx);
  assign w_last_op = (r_op_idx == elem_last_idx(r_elem));
  assign w_dir_up  = elem_up(r_elem);
  assign mem_addr  = ag_address;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_elem   <= '0;
      r_op_idx <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_elem   <= w_elem_nxt;
      r_op_idx <= w_op_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_elem_nxt   = r_elem;
    w_op_idx_nxt = r_op_idx;
    w_start_acc  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    ag_clear     = 1'b0;
    ag_preset    = 1'b0;
    ag_en        = 1'b0;
    ag_up_down   = 1'b1;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_wdata    = '0;
    case (r_state)
      ST_IDLE: begin
        // Hold the generator at address 0 while waiting.
        ag_clear = 1'b1;
        if (start) begin
          w_start_acc  = 1'b1;
          w_state_nxt  = ST_SETUP;
          w_elem_nxt   = '0;
          w_op_idx_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        // Load the sweep start address: 0 for up, all-ones for down.
        busy         = 1'b1;
        ag_up_down   = w_dir_up;
        ag_clear     = w_dir_up;
        ag_preset    = !w_dir_up;
        w_op_idx_nxt = 1'b0;
        w_state_nxt  = ST_OP;
      end
      ST_OP: begin
        busy       = 1'b1;
        ag_up_down = w_dir_up;
        mem_re     = op_is_read(w_op);
        mem_we     = !op_is_read(w_op);
        mem_wdata  = {D_WIDTH{w_op == OP_W1}};
        if (w_last_op) begin
          w_op_idx_nxt = 1'b0;
          if (ag_carry) begin
            // End of sweep: advance without stepping, so the address never wraps.
            if (r_elem == LAST_ELEM) begin
              w_state_nxt = ST_DRAIN;
            end else begin
              w_elem_nxt  = r_elem + 3'd1;
              w_state_nxt = ST_SETUP;
            end
          end else begin
            ag_en = 1'b1;
          end
        end else begin
          w_op_idx_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Gives the comparator one cycle to check the final read.
        busy        = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  march_comparator #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_cmp (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_start_acc),
    .i_rd_en     (mem_re),
    .i_exp       ({D_WIDTH{w_op == OP_R1}}),
    .i_addr      (ag_address),
    .i_elem      (r_elem),
    .i_rdata     (mem_rdata),
    .o_fail      (fail),
    .o_fail_addr (fail_addr),
    .o_fail_elem (fail_elem)
  );

endmodule
